// File: rtl/shift_seq_ctrl_pkg.sv
// Shared types for the multi-cycle EX-stage shift controller.
// SH_ROTR behaviour depends on the SHIFT_ROTATE_EN macro (see shift_step).
package shift_pkg;

    localparam int unsigned AMT_W = 5;

    typedef enum logic [1:0] {
        SH_SLL  = 2'b00,
        SH_SRL  = 2'b01,
        SH_SRA  = 2'b10,
        SH_ROTR = 2'b11
    } shift_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_DONE
    } state_e;

endpackage

// File: rtl/shift_seq_ctrl_if.sv
// Request/response bundle between the EX stage and the shift controller.
interface shift_seq_ctrl_if #(
    parameter int unsigned W = 32
);
    logic         start;
    logic [1:0]   op;
    logic         var_sel;
    logic [W-1:0] rt_data;
    logic [W-1:0] amt_data;
    logic         flush;
    logic         m3;
    logic         busy;
    logic         done;
    logic [W-1:0] result;

    modport master (
        output start, op, var_sel, rt_data, amt_data, flush,
        input  m3, busy, done, result
    );

    modport slave (
        input  start, op, var_sel, rt_data, amt_data, flush,
        output m3, busy, done, result
    );
endinterface

// File: rtl/shift_seq_ctrl_shift_step.sv
// Combinational single-step shifter: moves work by n bits (n <= STEP).
// SHIFT_ROTATE_EN defined: SH_ROTR rotates right; otherwise SH_ROTR passes work through.
module shift_step
    import shift_pkg::*;
#(
    parameter int unsigned W = 32
) (
    input  logic [W-1:0]     work,
    input  logic [1:0]       op,
    input  logic [AMT_W-1:0] n,
    input  logic             sign,
    output logic [W-1:0]     next
);
    logic [W-1:0] fill;
    int unsigned  back;

    always_comb begin
        fill = sign ? ~({W{1'b1}} >> n) : '0;
        back = W - int'(n);
        case (shift_op_e'(op))
            SH_SLL:  next = work << n;
            SH_SRL:  next = work >> n;
            SH_SRA:  next = (work >> n) | fill;
`ifdef SHIFT_ROTATE_EN
            default: next = (work >> n) | (work << back);
`else
            default: next = work;
`endif
        endcase
    end
endmodule

// File: rtl/shift_seq_ctrl.sv
// Multi-cycle shift controller: drives the shift-amount mux select (m3), shifts up to
// STEP bits per cycle and reports busy/done. SHIFT_ROTATE_EN enables SH_ROTR rotation.
module shift_seq_ctrl
    import shift_pkg::*;
#(
    parameter int unsigned STEP = 1,
    parameter int unsigned W    = 32
) (
    input logic              clk,
    input logic              rst_n,
    shift_seq_ctrl_if.slave  io
);
    localparam logic [AMT_W-1:0] STEP_A = AMT_W'(STEP);

    state_e           state;
    logic [1:0]       op_q;
    logic [W-1:0]     work;
    logic [W-1:0]     step_out;
    logic [AMT_W-1:0] rem;
    logic [AMT_W-1:0] n;
    logic             sign;
    logic             m3_q, busy_q, done_q;
    logic [W-1:0]     result_q;
    logic             unused_amt_hi;

    assign unused_amt_hi = ^io.amt_data[W-1:AMT_W];
    assign n = (rem > STEP_A) ? STEP_A : rem;

    shift_step #(.W(W)) u_step (
        .work (work),
        .op   (op_q),
        .n    (n),
        .sign (sign),
        .next (step_out)
    );

    // result/done are loaded on the edge that enters ST_DONE so they are visible
    // during the DONE cycle itself; ST_DONE then only retires busy.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            op_q     <= SH_SLL;
            work     <= '0;
            rem      <= '0;
            sign     <= 1'b0;
            m3_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            done_q <= 1'b0;
            if (io.flush && state != ST_IDLE) begin
                state  <= ST_IDLE;
                busy_q <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (io.start && !io.flush) begin
                            op_q   <= io.op;
                            work   <= io.rt_data;
                            sign   <= io.rt_data[W-1];
                            m3_q   <= io.var_sel;
                            busy_q <= 1'b1;
                            state  <= ST_LOAD;
                        end
                    end
                    ST_LOAD: begin
                        rem <= io.amt_data[AMT_W-1:0];
                        if (io.amt_data[AMT_W-1:0] == '0) begin
                            result_q <= work;
                            done_q   <= 1'b1;
                            state    <= ST_DONE;
                        end else begin
                            state <= ST_SHIFT;
                        end
                    end
                    ST_SHIFT: begin
                        work <= step_out;
                        rem  <= rem - n;
                        if (rem == n) begin
                            result_q <= step_out;
                            done_q   <= 1'b1;
                            state    <= ST_DONE;
                        end
                    end
                    default: begin
                        busy_q <= 1'b0;
                        state  <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign io.m3     = m3_q;
    assign io.busy   = busy_q;
    assign io.done   = done_q;
    assign io.result = result_q;
endmodule
